// File: rtl/repeated_subtract_divider_pkg.sv
// Shared definitions for the repeated-subtraction divider: FSM state encoding
// and the default datapath width.
package repeated_subtract_divider_pkg;

    localparam int unsigned DATA_W = 8;

    // 2'd3 is never entered; the FSM decodes it as IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/repeated_subtract_divider_subtractor.sv
// N-bit combinational subtractor A-B; borrow is the counterpart of the adder's
// carry out and is 0 exactly when A >= B.
module n_bit_subtractor
    import repeated_subtract_divider_pkg::*;
#(
    parameter int unsigned N = DATA_W
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] Diff,
    output logic         borrow
);

    logic [N:0] w_wide;

    always_comb begin
        w_wide = {1'b0, A} - {1'b0, B};
        Diff   = w_wide[N-1:0];
        borrow = w_wide[N];
    end

endmodule

// File: rtl/repeated_subtract_divider.sv
// Sequential unsigned divider: subtracts the captured divisor once per clock
// until the remainder drops below it; the subtraction count is the quotient.
module repeated_subtract_divider
    import repeated_subtract_divider_pkg::*;
#(
    parameter int unsigned N = DATA_W
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Start,
    input  logic [N-1:0] Dividend,
    input  logic [N-1:0] Divisor,
    output logic [N-1:0] Quotient,
    output logic [N-1:0] Remainder,
    output logic         Busy,
    output logic         Done,
    output logic         DivZero
);

    state_t       r_state;
    state_t       w_state_nxt;
    logic [N-1:0] r_divisor;
    logic [N-1:0] r_quot;
    logic [N-1:0] r_rem;
    logic         r_divzero;

    logic         w_load;
    logic         w_step;
    logic [N-1:0] w_diff;
    logic         w_borrow;

    n_bit_subtractor #(
        .N (N)
    ) u_sub (
        .A      (r_rem),
        .B      (r_divisor),
        .Diff   (w_diff),
        .borrow (w_borrow)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        Busy        = 1'b0;
        Done        = 1'b0;
        case (r_state)
            ST_RUN: begin
                Busy = 1'b1;
                if (!w_borrow) begin
                    w_step = 1'b1;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                Busy        = 1'b1;
                Done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                // Covers ST_IDLE and the unused encoding 2'd3.
                if (Start) begin
                    w_load      = 1'b1;
                    w_state_nxt = (Divisor == '0) ? ST_DONE : ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_divisor <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_divzero <= 1'b0;
        end else if (w_load) begin
            r_divisor <= Divisor;
            r_quot    <= '0;
            r_rem     <= Dividend;
            r_divzero <= (Divisor == '0);
        end else if (w_step) begin
            r_quot <= r_quot + 1'b1;
            r_rem  <= w_diff;
        end
    end

    always_comb begin
        Quotient  = r_quot;
        Remainder = r_rem;
        DivZero   = r_divzero;
    end

endmodule

// File: tb/tb_repeated_subtract_divider.sv
// Directed bench for repeated_subtract_divider with an expected-result queue
// filled at each accepted Start and drained on each Done.
module tb_repeated_subtract_divider;

    localparam int unsigned N = 8;

    logic         Clock = 1'b0;
    logic         Reset = 1'b1;
    logic         Start = 1'b0;
    logic [N-1:0] Dividend = '0;
    logic [N-1:0] Divisor = '0;
    logic [N-1:0] Quotient;
    logic [N-1:0] Remainder;
    logic         Busy;
    logic         Done;
    logic         DivZero;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    repeated_subtract_divider #(
        .N (N)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Start     (Start),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Busy      (Busy),
        .Done      (Done),
        .DivZero   (DivZero)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // Expected result from plain arithmetic; latency counts the cycle after
    // the accepting edge as cycle 1.
    task automatic push_exp(input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t e;
        if (b == 0) begin
            e.q = '0; e.r = a; e.dz = 1'b1; e.lat = 1;
        end else begin
            e.q = a / b; e.r = a % b; e.dz = 1'b0; e.lat = int'(a / b) + 2;
        end
        sb.push_back(e);
    endtask

    task automatic start_div(input logic [N-1:0] a, input logic [N-1:0] b, input bit push);
        @(negedge Clock);
        Dividend = a;
        Divisor  = b;
        Start    = 1'b1;
        @(posedge Clock);
        if (push) push_exp(a, b);
    endtask

    // Waits for Done (bounded), then compares against the queue head.
    task automatic wait_done(input string tag, input bit hold, input int chg_at);
        int   c;
        int   busy_cnt;
        bit   found;
        exp_t e;
        found = 0;
        busy_cnt = 0;
        for (c = 1; c <= 300; c++) begin
            @(negedge Clock);
            if (!hold) Start = 1'b0;
            if (c == chg_at) Dividend = '0;
            if (Busy) busy_cnt++;
            if (Done === 1'b1) begin
                found = 1;
                break;
            end
        end
        chk({tag, "_done_seen"}, found, 1);
        if (!found || sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, sb.size(), 1);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_latency"}, c, e.lat);
        chk({tag, "_busy_cycles"}, busy_cnt, e.lat);
        chk({tag, "_quot"}, Quotient, e.q);
        chk({tag, "_rem"}, Remainder, e.r);
        chk({tag, "_divzero"}, DivZero, e.dz);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        chk("rst_quot", Quotient, 0);
        chk("rst_rem", Remainder, 0);
        chk("rst_divzero", DivZero, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);

        // 1: 200/7, Done one cycle only, result held in IDLE
        start_div(8'd200, 8'd7, 1);
        wait_done("d200_7", 0, 0);
        @(negedge Clock);
        chk("d200_7_done_pulse", Done, 0);
        chk("d200_7_idle_busy", Busy, 0);
        repeat (3) @(negedge Clock);
        chk("d200_7_hold_quot", Quotient, 28);
        chk("d200_7_hold_rem", Remainder, 4);

        // 2: 5/9, dividend smaller than divisor
        start_div(8'd5, 8'd9, 1);
        wait_done("d5_9", 0, 0);

        // 3: 255/1 worst case
        start_div(8'd255, 8'd1, 1);
        wait_done("d255_1", 0, 0);

        // 4: divide by zero, then a normal divide clears DivZero
        start_div(8'd77, 8'd0, 1);
        wait_done("d77_0", 0, 0);
        repeat (2) @(negedge Clock);
        chk("d77_0_dz_hold", DivZero, 1);
        start_div(8'd12, 8'd4, 1);
        wait_done("d12_4", 0, 0);

        // 5: reset mid-run abandons the division
        start_div(8'd100, 8'd3, 0);
        for (int i = 1; i <= 10; i++) begin
            @(negedge Clock);
            Start = 1'b0;
        end
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        chk("mid_rst_quot", Quotient, 0);
        chk("mid_rst_rem", Remainder, 0);
        chk("mid_rst_busy", Busy, 0);
        chk("mid_rst_done", Done, 0);
        chk("mid_rst_divzero", DivZero, 0);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge Clock);
                if (Done === 1'b1 || Busy === 1'b1) seen++;
            end
            chk("mid_rst_no_done", seen, 0);
        end
        start_div(8'd100, 8'd3, 1);
        wait_done("d100_3", 0, 0);

        // 6: Start held high; operand change after capture; Start in DONE ignored
        start_div(8'd60, 8'd6, 1);
        wait_done("d60_6", 1, 3);
        @(negedge Clock);
        chk("held_idle_busy", Busy, 0);
        chk("held_idle_done", Done, 0);
        chk("held_idle_quot", Quotient, 10);
        push_exp(8'd0, 8'd6);
        wait_done("d0_6_reaccept", 0, 0);
        @(negedge Clock);
        chk("final_busy", Busy, 0);
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
